button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumer-side decoder for a debounced push-button level.
- Turns the clean level into single-cycle event pulses: press, release, short-click, long-press and auto-repeat.
- Sits between the button debouncer outputs and the application FSMs (e.g. vending-machine control).
- The application never handles raw levels or timing itself.

Parameters:
- CLK_FREQ, 25_000_000, clock frequency in Hz.
- LONG_PRESS_MS, 800, hold time before long_o fires; LONG_CYCLES = CLK_FREQ*LONG_PRESS_MS/1000, must be >= 2.
- REPEAT_MS, 200, auto-repeat period after long_o; REPEAT_CYCLES = CLK_FREQ*REPEAT_MS/1000, must be >= 2.
- DOUBLE_MS, 300, double-click window (used only with the optional feature); DOUBLE_CYCLES computed the same way.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- level_i  in  1  debounced button level, 1 = pressed; synchronous to clk_i.
- held_o  out  1  registered copy of the pressed state.
- press_o  out  1  one-cycle pulse on press.
- release_o  out  1  one-cycle pulse on release.
- short_o  out  1  one-cycle pulse on release before long_o fired.
- long_o  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_o  out  1  one-cycle pulse every REPEAT_CYCLES after long_o while still held.
- double_o  out  1  one-cycle pulse on the second press of a double-click; constant 0 when the feature is compiled out.

Behaviour:
- Interface decided: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - level_q (edge register) = 0.
  - State IDLE.
  - Counter 0.
- Reset mid-operation: aborts any hold silently; no release_o is emitted.
- Button held through reset: produces press_o on the first cycle after reset deassertion, because level_q resets to 0.
- Edge detection:
  - rise = level_i & ~level_q; fall = ~level_i & level_q.
  - All outputs are registered, so each event pulse appears in the cycle after level_i changes (1-cycle latency).
- States: IDLE, HOLD, REPEAT. Counter is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)) bits wide; it saturates and never wraps.
- IDLE:
  - On rise: press_o=1, held_o<=1, counter<=0, go to HOLD.
  - fall is impossible in IDLE; ignore it.
- HOLD:
  - Counter increments each cycle.
  - On fall: release_o=1 and short_o=1, held_o<=0, go to IDLE.
  - Else if counter == LONG_CYCLES-1: long_o=1, counter<=0, go to REPEAT.
- REPEAT:
  - On fall: release_o=1 only (no short_o), held_o<=0, go to IDLE.
  - Else if counter == REPEAT_CYCLES-1: repeat_o=1, counter<=0.
  - Else the counter increments.
- Simultaneous events: release has priority over the long/repeat threshold in the same cycle.
  - Fall at the LONG threshold yields short_o + release_o, and no long_o.
- Pulse rules: at most one of press_o / long_o / repeat_o / release_o per cycle; short_o and double_o accompany release_o / press_o respectively.
- The first repeat_o occurs exactly REPEAT_CYCLES cycles after long_o.

Optional Feature:
- Macro: BUTTON_EVENT_DOUBLE_EN.
- With the macro defined:
  - A second counter (gap timer) loads 0 on every short_o, then counts up to DOUBLE_CYCLES and saturates there.
  - A rise while the gap timer is < DOUBLE_CYCLES pulses double_o in the same cycle as press_o, then disarms the window.
  - A release after long_o, or reset, disarms the window.
  - The third click of a triple-click starts a fresh pairing; it does not produce double_o.
- Without the macro: double_o is tied 0, the gap timer is absent, and DOUBLE_MS is ignored.

Decomposition:
- Package button_event_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, HOLD, REPEAT};
  - function ms_to_cycles(clk_freq, ms);
- One natural sub-module, ms_timer: clear input, enable input, saturating count, expire flag at a compare value.
  - Used once for hold/repeat and once for the double-click gap.

Test Plan:
- All tests use CLK_FREQ=1000, LONG_PRESS_MS=10, REPEAT_MS=4, DOUBLE_MS=6, so 1 cycle = 1 ms.
- Short click: level_i high for 5 cycles, then low -> press_o at cycle t+1; release_o and short_o together at cycle t+6; long_o never fires.
- Long hold: level_i high for 25 cycles -> press_o; long_o 10 cycles after press_o; repeat_o 4, 8 and 12 cycles after long_o; on release, release_o with no short_o.
- Threshold race: level_i falls in the exact cycle the counter hits 9 -> short_o + release_o; long_o stays 0.
- Async reset mid-hold: assert rst_i asynchronously 3 cycles into the hold -> all outputs 0 immediately, no release_o.
  - Keep level_i high through reset -> press_o in the first cycle after deassertion.
- Double-click (macro on): two 2-cycle clicks separated by a 3-cycle gap -> double_o with the second press_o.
  - A gap of 7 cycles -> no double_o.
  - Macro off -> double_o always 0.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types and helpers for the button_event decoder.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Milliseconds to clock cycles; widened so 25 MHz * 800 ms does not overflow.
    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        longint prod;
        prod = longint'(clk_freq) * longint'(ms);
        return int'(prod / longint'(1000));
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Saturating up-counter with synchronous clear and an expire flag at a compare value.
module ms_timer #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] cmp_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (en_i && (r_count != MAX_COUNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired_o = (r_count == cmp_i);

endmodule

// File: rtl/button_event.sv
// Debounced button level to press/release/short/long/repeat event pulses.
// Define BUTTON_EVENT_DOUBLE_EN to build the double-click detector on double_o.
module button_event
    import button_event_pkg::*;
#(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int LONG_PRESS_MS = 800,
    parameter int REPEAT_MS     = 200,
    parameter int DOUBLE_MS     = 300
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic held_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic double_o
);

    localparam int LONG_CYCLES   = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
    localparam int REPEAT_CYCLES = ms_to_cycles(CLK_FREQ, REPEAT_MS);
    localparam int MAX_CYCLES    = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W         = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] LONG_CMP   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_CMP = CNT_W'(REPEAT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_level_q;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_cnt_hit;
    logic [CNT_W-1:0] w_cnt_cmp;

    logic w_held_nxt, w_press_nxt, w_release_nxt, w_short_nxt, w_long_nxt, w_repeat_nxt;
    logic r_held, r_press, r_release, r_short, r_long, r_repeat;

    assign w_rise    = level_i & ~r_level_q;
    assign w_fall    = ~level_i & r_level_q;
    assign w_cnt_en  = (r_state != IDLE);
    assign w_cnt_cmp = (r_state == REPEAT) ? REPEAT_CMP : LONG_CMP;

    ms_timer #(
        .WIDTH (CNT_W)
    ) u_hold_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_cnt_clr),
        .en_i      (w_cnt_en),
        .cmp_i     (w_cnt_cmp),
        .expired_o (w_cnt_hit)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_held_nxt    = r_held;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_short_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_cnt_clr     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (w_rise) begin
                    w_press_nxt = 1'b1;
                    w_held_nxt  = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Release wins over the long threshold landing in the same cycle.
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_short_nxt   = 1'b1;
                    w_held_nxt    = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (w_cnt_hit) begin
                    w_long_nxt  = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = REPEAT;
                end
            end
            REPEAT: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_held_nxt    = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (w_cnt_hit) begin
                    w_repeat_nxt = 1'b1;
                    w_cnt_clr    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_level_q <= 1'b0;
            r_held    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_level_q <= level_i;
            r_held    <= w_held_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_short   <= w_short_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    assign held_o    = r_held;
    assign press_o   = r_press;
    assign release_o = r_release;
    assign short_o   = r_short;
    assign long_o    = r_long;
    assign repeat_o  = r_repeat;

`ifdef BUTTON_EVENT_DOUBLE_EN
    localparam int               DOUBLE_CYCLES = ms_to_cycles(CLK_FREQ, DOUBLE_MS);
    localparam int               GAP_W         = $clog2(DOUBLE_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX       = GAP_W'(DOUBLE_CYCLES);

    logic w_gap_expired;
    logic w_double_nxt;
    logic r_armed;
    logic r_pair;
    logic r_double;

    ms_timer #(
        .WIDTH     (GAP_W),
        .MAX_COUNT (GAP_MAX)
    ) u_gap_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_short_nxt),
        .en_i      (1'b1),
        .cmp_i     (GAP_MAX),
        .expired_o (w_gap_expired)
    );

    assign w_double_nxt = w_press_nxt & r_armed & ~w_gap_expired;

    // r_pair marks the second click of a pair so its release does not re-arm the window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_armed  <= 1'b0;
            r_pair   <= 1'b0;
            r_double <= 1'b0;
        end else begin
            r_double <= w_double_nxt;
            if (w_double_nxt) begin
                r_armed <= 1'b0;
                r_pair  <= 1'b1;
            end else if (w_short_nxt) begin
                r_armed <= ~r_pair;
                r_pair  <= 1'b0;
            end else if (w_release_nxt) begin
                r_armed <= 1'b0;
                r_pair  <= 1'b0;
            end
        end
    end

    assign double_o = r_double;
`else
    assign double_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event at 1 ms per cycle (LONG=10, REPEAT=4, DOUBLE=6 cycles).
module tb_button_event;

    logic clk_i = 1'b0;
    logic rst_i;
    logic level_i;
    logic held_o, press_o, release_o, short_o, long_o, repeat_o, double_o;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BUTTON_EVENT_DOUBLE_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    button_event #(
        .CLK_FREQ      (1000),
        .LONG_PRESS_MS (10),
        .REPEAT_MS     (4),
        .DOUBLE_MS     (6)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .level_i   (level_i),
        .held_o    (held_o),
        .press_o   (press_o),
        .release_o (release_o),
        .short_o   (short_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o),
        .double_o  (double_o)
    );

    always #5 clk_i = ~clk_i;

    // Output vector order: held, press, release, short, long, repeat, double.
    logic [6:0] obs;
    assign obs = {held_o, press_o, release_o, short_o, long_o, repeat_o, double_o};

    function automatic logic [6:0] ev(input bit held, input bit press, input bit rel,
                                      input bit sh, input bit lg, input bit rp, input bit db);
        return {held, press, rel, sh, lg, rp, db};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        level_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst_i   = 1'b1;
        level_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        exp = '0;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_asserted got=%b expected=%b", obs, exp);
        end
        n_cmp++;
        rst_i = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_idle c=%0d got=%b expected=%b", c, obs, exp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_short_click();
        logic [6:0] exp;
        level_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = ev(c <= 5, c == 1, c == 6, c == 6, 1'b0, 1'b0, 1'b0);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL short_click c=%0d got=%b expected=%b", c, obs, exp);
            end
            n_cmp++;
            if (c == 5) level_i = 1'b0;
        end
    endtask

    task automatic test_long_hold();
        logic [6:0] exp;
        level_i = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            exp = ev(c <= 25, c == 1, c == 26, 1'b0, c == 11,
                     (c == 15) || (c == 19) || (c == 23), 1'b0);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL long_hold c=%0d got=%b expected=%b", c, obs, exp);
            end
            n_cmp++;
            if (c == 25) level_i = 1'b0;
        end
    endtask

    task automatic test_threshold_race();
        logic [6:0] exp;
        level_i = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp = ev(c <= 10, c == 1, c == 11, c == 11, 1'b0, 1'b0, 1'b0);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL threshold_race c=%0d got=%b expected=%b", c, obs, exp);
            end
            n_cmp++;
            if (c == 10) level_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [6:0] exp;
        level_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            exp = ev(1'b1, c == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL mid_hold_pre c=%0d got=%b expected=%b", c, obs, exp);
            end
            n_cmp++;
        end
        #3 rst_i = 1'b1;
        #1;
        exp = '0;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL mid_hold_async got=%b expected=%b", obs, exp);
        end
        n_cmp++;
        for (int c = 1; c <= 2; c++) begin
            tick();
            if (obs !== exp) begin
                n_err++;
                $display("FAIL mid_hold_in_reset c=%0d got=%b expected=%b", c, obs, exp);
            end
            n_cmp++;
        end
        #2 rst_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp = ev(c <= 2, c == 1, c == 3, c == 3, 1'b0, 1'b0, 1'b0);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL mid_hold_after c=%0d got=%b expected=%b", c, obs, exp);
            end
            n_cmp++;
            if (c == 2) level_i = 1'b0;
        end
    endtask

    task automatic test_double();
        int         gaps [7] = '{0, 3, 3, 3, 8, 7, 6};
        bit         dbl  [7] = '{0, 1, 0, 1, 0, 0, 1};
        logic [6:0] exp;
        for (int i = 0; i < 7; i++) begin
            for (int j = 1; j < gaps[i]; j++) begin
                tick();
                exp = '0;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL double_gap click=%0d j=%0d got=%b expected=%b", i, j, obs, exp);
                end
                n_cmp++;
            end
            level_i = 1'b1;
            tick();
            exp = ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dbl[i] & DBL_EN);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL double_press click=%0d got=%b expected=%b", i, obs, exp);
            end
            n_cmp++;
            tick();
            exp = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL double_hold click=%0d got=%b expected=%b", i, obs, exp);
            end
            n_cmp++;
            level_i = 1'b0;
            tick();
            exp = ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (obs !== exp) begin
                n_err++;
                $display("FAIL double_release click=%0d got=%b expected=%b", i, obs, exp);
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_short_click();
        idle(10);
        test_long_hold();
        idle(10);
        test_threshold_race();
        idle(10);
        test_reset_mid_hold();
        idle(10);
        test_double();
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
